// File: rtl/alu_pkg.sv
// Shared ALU types: operation encoding, data word, sequencer FSM states.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package alu_pkg;

  // Architectural data word; alu_seq WIDTH must match this width.
  typedef logic [31:0] UbitData;

  // Ten-operation set. Encodings 10..15 are undefined and produce 0.
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLT  = 4'd5,
    SLTU = 4'd6,
    SLL  = 4'd7,
    SRL  = 4'd8,
    SRA  = 4'd9
  } Op;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } AluSeqState;

  function automatic logic is_shift(Op op);
    return (op == SLL) || (op == SRL) || (op == SRA);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between an ALU initiator (master) and alu_seq (slave).
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response channel.
// Signals: req_valid/req_ready/req_op/req_a/req_b, rsp_valid/rsp_ready/rsp_x,
// plus rsp_zero/rsp_ovf when ALU_SEQ_FLAGS_EN is defined.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  import alu_pkg::*;

  logic             req_valid;
  logic             req_ready;
  Op                req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_x;
`ifdef ALU_SEQ_FLAGS_EN
  logic             rsp_zero;
  logic             rsp_ovf;
`endif

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
`ifdef ALU_SEQ_FLAGS_EN
    input  rsp_zero, rsp_ovf,
`endif
    input  req_ready, rsp_valid, rsp_x
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
`ifdef ALU_SEQ_FLAGS_EN
    output rsp_zero, rsp_ovf,
`endif
    output req_ready, rsp_valid, rsp_x
  );

endinterface

// File: rtl/alu_seq_shift_step.sv
// One bounded shift step (SLL/SRL/SRA by s <= SHIFT_STEP); other ops pass value through.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: value (word to shift), op (selects direction/fill), s (step amount),
// shifted (result).
module alu_seq_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SW    = 3
) (
  input  logic [WIDTH-1:0] value,
  input  Op                op,
  input  logic [SW-1:0]    s,
  output logic [WIDTH-1:0] shifted
);

  // s is only SW bits wide, so this is a shallow mux tree rather than a
  // full-width barrel shifter.
  always_comb begin
    shifted = value;
    case (op)
      SLL:     shifted = value << s;
      SRL:     shifted = value >> s;
      SRA:     shifted = unsigned'($signed(value) >>> s);
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative shifts SHIFT_STEP bits/cycle.
// Latency: 1 cycle accept->rsp_valid; shifts 1 + ceil(amt/SHIFT_STEP); one op per 2 cycles peak.
// Backpressure: req_ready only in IDLE; result held in RESP until rsp_ready.
// Ports: clk, rst_n (async active-low), bus (alu_seq_if slave: request/response
// channels), busy (high outside IDLE). Define ALU_SEQ_FLAGS_EN to add
// rsp_zero/rsp_ovf on the response channel.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus,
  output logic       busy
);

  localparam int AW = $clog2(WIDTH);          // shift amount width
  localparam int SW = $clog2(SHIFT_STEP + 1); // holds 0..SHIFT_STEP

  AluSeqState       state_q, state_d;
  Op                op_q, op_d;
  logic [WIDTH-1:0] val_q, val_d;   // working value while shifting
  logic [AW-1:0]    rem_q, rem_d;   // shift bits still to apply
  logic [WIDTH-1:0] x_q, x_d;

  logic [AW-1:0]    amt;
  logic [SW-1:0]    step;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] alu_x;

`ifdef ALU_SEQ_FLAGS_EN
  logic             alu_ovf;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
`endif

  // Upper bits of b are ignored for shifts.
  assign amt = bus.req_b[AW-1:0];

  // Single-cycle result from the live request. Shift ops return a unchanged,
  // which is exactly the answer for a zero shift amount.
  always_comb begin
    alu_x = '0;
`ifdef ALU_SEQ_FLAGS_EN
    alu_ovf = 1'b0;
`endif
    case (bus.req_op)
      ADD: begin
        alu_x = bus.req_a + bus.req_b;
`ifdef ALU_SEQ_FLAGS_EN
        // Like-signed operands producing an opposite-signed sum.
        alu_ovf = (bus.req_a[WIDTH-1] == bus.req_b[WIDTH-1]) &&
                  (alu_x[WIDTH-1] != bus.req_a[WIDTH-1]);
`endif
      end
      SUB: begin
        alu_x = bus.req_a - bus.req_b;
`ifdef ALU_SEQ_FLAGS_EN
        // Unlike-signed operands where the difference takes b's sign.
        alu_ovf = (bus.req_a[WIDTH-1] != bus.req_b[WIDTH-1]) &&
                  (alu_x[WIDTH-1] != bus.req_a[WIDTH-1]);
`endif
      end
      AND:  alu_x = bus.req_a & bus.req_b;
      OR:   alu_x = bus.req_a | bus.req_b;
      XOR:  alu_x = bus.req_a ^ bus.req_b;
      SLT:  alu_x = {{(WIDTH-1){1'b0}}, ($signed(bus.req_a) < $signed(bus.req_b))};
      SLTU: alu_x = {{(WIDTH-1){1'b0}}, (bus.req_a < bus.req_b)};
      SLL, SRL, SRA: alu_x = bus.req_a;
      default: alu_x = '0;
    endcase
  end

  // Step size this cycle: min(remaining, SHIFT_STEP). Compared as int so a
  // SHIFT_STEP equal to WIDTH does not overflow the AW-bit amount.
  always_comb begin
    if (int'(rem_q) >= SHIFT_STEP) step = SW'(SHIFT_STEP);
    else                           step = SW'(rem_q);
  end

  alu_seq_shift_step #(
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_shift_step (
    .value   (val_q),
    .op      (op_q),
    .s       (step),
    .shifted (shifted)
  );

  // Next-state and datapath next values.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    val_d   = val_q;
    rem_d   = rem_q;
    x_d     = x_q;
`ifdef ALU_SEQ_FLAGS_EN
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d  = bus.req_op;
          val_d = bus.req_a;
          rem_d = amt;
          if (is_shift(bus.req_op) && (amt != '0)) begin
            state_d = SHIFT;
          end else begin
            x_d     = alu_x;
            state_d = RESP;
`ifdef ALU_SEQ_FLAGS_EN
            zero_d  = (alu_x == '0);
            ovf_d   = alu_ovf;
`endif
          end
        end
      end
      SHIFT: begin
        val_d = shifted;
        rem_d = rem_q - AW'(step);
        if (rem_d == '0) begin
          x_d     = shifted;
          state_d = RESP;
`ifdef ALU_SEQ_FLAGS_EN
          zero_d  = (shifted == '0);
          ovf_d   = 1'b0;
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= ADD;
      val_q  <= '0;
      rem_q  <= '0;
      x_q    <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      op_q   <= op_d;
      val_q  <= val_d;
      rem_q  <= rem_d;
      x_q    <= x_d;
`ifdef ALU_SEQ_FLAGS_EN
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_x     = x_q;
  assign busy          = (state_q != IDLE);
`ifdef ALU_SEQ_FLAGS_EN
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, hand-written
// backpressure / reset-mid-shift sequences, then random ops vs a reference model.
// Flags are checked when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W    = 32;
  localparam int STEP = 4;

  logic clk;
  logic rst_n;
  logic busy;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(
    .WIDTH      (W),
    .SHIFT_STEP (STEP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [31:0] ref_x(Op op, logic [31:0] a, logic [31:0] b);
    int unsigned amt;
    amt = b % 32;
    case (op)
      ADD:  return a + b;
      SUB:  return a - b;
      AND:  return a & b;
      OR:   return a | b;
      XOR:  return a ^ b;
      SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLTU: return (a < b) ? 32'd1 : 32'd0;
      SLL:  return a << amt;
      SRL:  return a >> amt;
      SRA:  return $signed(a) >>> amt;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(Op op, logic [31:0] b);
    int unsigned amt;
    amt = b % 32;
    if ((op == SLL || op == SRL || op == SRA) && amt != 0)
      return 1 + (amt + STEP - 1) / STEP;
    return 1;
  endfunction

  function automatic logic ref_ovf(Op op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == ADD) r = sa + sb;
    else if (op == SUB) r = sa - sb;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // ---------------- one request/response transaction ----------------
  // Latency = rising edges from the accepting edge to the first cycle rsp_valid is seen.
  task automatic run_op(input Op op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] x, output int lat,
                        output logic z, output logic o);
    int guard;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      n_total++;
      $display("FAIL accept_timeout: req_ready stayed 0 for 50 cycles, required 1");
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.rsp_valid) begin
      n_total++;
      $display("FAIL rsp_timeout: rsp_valid stayed 0 for 50 cycles, required 1");
    end
    x = bus.rsp_x;
`ifdef ALU_SEQ_FLAGS_EN
    z = bus.rsp_zero;
    o = bus.rsp_ovf;
`else
    z = 1'b0;
    o = 1'b0;
`endif
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    Op           op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] x;
    int          lat;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] x;
    int          lat;
    logic        z, o;
    Op           rop;
    logic [31:0] ra, rb;

    vecs.push_back('{ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1'b1, 1'b0});
    vecs.push_back('{SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1, 1'b0, 1'b0});
    vecs.push_back('{SLTU, 32'h80000000, 32'h00000001, 32'h00000000, 1, 1'b1, 1'b0});
    vecs.push_back('{SRA,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 9, 1'b0, 1'b0});
    vecs.push_back('{SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 9, 1'b0, 1'b0});
    vecs.push_back('{SLL,  32'h00000001, 32'h00000020, 32'h00000001, 1, 1'b0, 1'b0});
    vecs.push_back('{XOR,  32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 1, 1'b0, 1'b0});
    vecs.push_back('{ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 1'b0, 1'b1});
    vecs.push_back('{SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 1'b0, 1'b1});
    vecs.push_back('{SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1, 1'b0, 1'b0});
    vecs.push_back('{AND,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1, 1'b0, 1'b0});
    vecs.push_back('{OR,   32'hFF00FF00, 32'h0FF00FF0, 32'hFFF0FFF0, 1, 1'b0, 1'b0});
    vecs.push_back('{SLL,  32'h00000001, 32'hFFFFFF04, 32'h00000010, 2, 1'b0, 1'b0});
    vecs.push_back('{SRA,  32'hF0000000, 32'h00000005, 32'hFF800000, 3, 1'b0, 1'b0});
    vecs.push_back('{Op'(4'd13), 32'h12345678, 32'h00000003, 32'h00000000, 1, 1'b1, 1'b0});

    // ---- reset state (asynchronous, before any clock edge) ----
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = ADD;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    #1;
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_x",     bus.rsp_x,          32'd0);
    check("reset_busy",      32'(busy),          32'd0);
`ifdef ALU_SEQ_FLAGS_EN
    check("reset_rsp_zero",  32'(bus.rsp_zero),  32'd0);
    check("reset_rsp_ovf",   32'(bus.rsp_ovf),   32'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // ---- directed vector table ----
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, x, lat, z, o);
      check($sformatf("vec%0d_x", i),   x,          vecs[i].x);
      check($sformatf("vec%0d_lat", i), 32'(lat),   32'(vecs[i].lat));
`ifdef ALU_SEQ_FLAGS_EN
      check($sformatf("vec%0d_zero", i), 32'(z),    32'(vecs[i].zero));
      check($sformatf("vec%0d_ovf", i),  32'(o),    32'(vecs[i].ovf));
`endif
    end

    // ---- backpressure: XOR held 5 cycles; a new request waits meanwhile ----
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = XOR;
    bus.req_a     = 32'hF0F0F0F0;
    bus.req_b     = 32'hFFFF0000;
    @(posedge clk);
    #1;
    bus.req_op    = ADD;   // next request presented while the block is busy
    bus.req_a     = 32'd1;
    bus.req_b     = 32'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp%0d_rsp_x", i),     bus.rsp_x,          32'h0F0FF0F0);
      check($sformatf("bp%0d_req_ready", i), 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_req_ready", 32'(bus.req_ready), 32'd1);
    check("bp_release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("bp_next_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp_next_rsp_x",     bus.rsp_x,          32'd3);
    @(posedge clk);
    #1;

    // ---- reset during the second SHIFT cycle of SLL by 20 ----
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = SLL;
    bus.req_a     = 32'h00000001;
    bus.req_b     = 32'd20;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("mid_shift_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_x",     bus.rsp_x,          32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy",      32'(busy),          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(SLL, 32'h00000001, 32'd20, x, lat, z, o);
    check("post_rst_x",   x,        32'h00100000);
    check("post_rst_lat", 32'(lat), 32'd6);

    // ---- randomized ops vs reference model ----
    for (int i = 0; i < 150; i++) begin
      rop = Op'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      run_op(rop, ra, rb, x, lat, z, o);
      check($sformatf("rnd%0d_x op=%0d a=%08h b=%08h", i, rop, ra, rb), x, ref_x(rop, ra, rb));
      check($sformatf("rnd%0d_lat op=%0d b=%08h", i, rop, rb), 32'(lat), 32'(ref_lat(rop, rb)));
`ifdef ALU_SEQ_FLAGS_EN
      check($sformatf("rnd%0d_zero", i), 32'(z), 32'(ref_x(rop, ra, rb) == 32'd0));
      check($sformatf("rnd%0d_ovf", i),  32'(o), 32'(ref_ovf(rop, ra, rb)));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
